bram_arbiter: RTL

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/bram_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the two-requester BRAM arbiter: requester count
// and controller state encoding.
package bram_arbiter_pkg;

   localparam int N_REQ = 2;

   typedef enum logic {
      ST_INIT = 1'b0,   // zero-filling the external BRAM
      ST_RUN  = 1'b1    // arbitrating requester traffic
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from i_valid and
// the priority pointer; the pointer moves only when something is granted.
module rr_arbiter2
   import bram_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic [N_REQ-1:0] i_valid,
   output logic [N_REQ-1:0] o_grant
);

   logic             r_prio_1;   // 1: requester 1 wins a tie, 0: requester 0 wins
   logic [N_REQ-1:0] w_grant;

   // Grant selection: a sole requester wins outright, a tie goes to the pointer.
   // NOTE: assigning a default first in always_comb keeps every path driven, so no latch is inferred.
   always_comb begin
      w_grant = '0;
      if (i_enable) begin
         if (&i_valid) begin
            w_grant = r_prio_1 ? 2'b10 : 2'b01;
         end else begin
            w_grant = i_valid;
         end
      end
   end

   assign o_grant = w_grant;

   // Pointer update: after serving requester 0, favour requester 1, and vice versa.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio_1 <= 1'b0;
      end else if (|w_grant) begin
         r_prio_1 <= w_grant[0];
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester front end for an external single-port synchronous BRAM.
// After reset the memory is optionally zero-filled (INIT), then requests
// are granted one per cycle in round-robin order (RUN). Each transfer gets
// a one-cycle completion pulse carrying the BRAM read data.
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ-1:0]          req_we,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_din,
   input  logic [DATA_WIDTH-1:0]     mem_dout,
   output logic                      init_done
);

   localparam state_t                RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_init_addr;
   logic [N_REQ-1:0]      r_rsp_valid;

   logic                  w_init;
   logic                  w_run;
   logic [N_REQ-1:0]      w_grant;
   logic                  w_sel;

   // rst_n gates the qualifiers directly so that asserting reset silences
   // ready, mem_we and init_done at once, even when reset lands in RUN.
   assign w_init = rst_n && (r_state == ST_INIT);
   assign w_run  = rst_n && (r_state == ST_RUN);

   rr_arbiter2 u_rr_arbiter2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_enable (w_run),
      .i_valid  (req_valid),
      .o_grant  (w_grant)
   );

   assign w_sel     = w_grant[1];
   assign req_ready = w_grant;
   assign init_done = w_run;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = mem_dout;

   // BRAM port mux: the zero-fill sweep in INIT, the granted requester in RUN.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = req_addr[0 +: ADDR_WIDTH];
      mem_din  = req_wdata[0 +: DATA_WIDTH];
      if (w_init) begin
         mem_we   = 1'b1;
         mem_addr = r_init_addr;
         mem_din  = '0;
      end else if (|w_grant) begin
         mem_we   = w_sel ? req_we[1] : req_we[0];
         mem_addr = req_addr[(w_sel ? ADDR_WIDTH : 0) +: ADDR_WIDTH];
         mem_din  = req_wdata[(w_sel ? DATA_WIDTH : 0) +: DATA_WIDTH];
      end
   end

   // Controller FSM: zero-fill sweep, RUN hand-over and response pulse pipeline.
   // NOTE: the memory array is external and has no reset; clearing it is done by the INIT sweep instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RESET_STATE;
         r_init_addr <= '0;
         r_rsp_valid <= '0;
      end else begin
         r_rsp_valid <= w_grant;
         if (r_state == ST_INIT) begin
            r_init_addr <= r_init_addr + 1'b1;
            if (r_init_addr == LAST_ADDR) begin
               r_state <= ST_RUN;
            end
         end
      end
   end

endmodule
